multicycle_mem_port: RTL and testbench
======================================

# multicycle_mem_port

Unified instruction/data memory port for the multi-cycle CPU. It sits directly downstream of the main control FSM and consumes its `MemRead`, `MemWrite`, `IorD` and `IRWrite` strobes. It performs word accesses with a programmable wait-state latency and returns a `o_busy`/`o_done` handshake, so the FSM can stall in its fetch and memory states. Read data lands in the instruction register (IR) or the memory data register (MDR).

## Interface
Parameters:
- `DEPTH`, 256: memory size in 32-bit words; power of two.
- `LATENCY`, 2: wait cycles per access; ≥1.
- `INIT_FILE`, "": hex image loaded into the array at elaboration when non-empty.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_memread`, in, 1: read request from the FSM.
- `i_memwrite`, in, 1: write request from the FSM.
- `i_iord`, in, 1: address select. 0 selects `i_pc`; 1 selects `i_aluout`.
- `i_irwrite`, in, 1: the read result also loads the IR.
- `i_pc`, in, 32: program counter.
- `i_aluout`, in, 32: data address from the ALU output register.
- `i_wdata`, in, 32: store data (register B).
- `o_ir`, out, 32: instruction register.
- `o_mdr`, out, 32: memory data register.
- `o_busy`, out, 1: access in progress.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_err`, out, 1: one-cycle pulse for a rejected request.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE. The state register is reset by `i_rst_n`.
- Requests are sampled only in IDLE. In every other state, request inputs are ignored.
- In IDLE, on a rising edge:
  - Address latch: the block latches `addr = i_iord ? i_aluout : i_pc`, plus `i_irwrite` and `i_wdata`.
  - Read: `i_memread` alone moves the block to RD_WAIT.
  - Write: `i_memwrite` alone moves the block to WR_WAIT.
  - Both high: rejected. `o_err` pulses for one cycle, the block stays in IDLE, and there is no access.
  - `addr[1:0] != 0`: rejected the same way, `o_err` pulses, no access.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- A wait counter loads `LATENCY-1` on acceptance and decrements each cycle in the WAIT states. When it reaches 0, the access executes on the next edge and the state moves to DONE.
  - RD_WAIT exit: `mem[idx]` is loaded into `o_mdr`. If the latched `i_irwrite` is 1, the same word is also loaded into `o_ir`.
  - WR_WAIT exit: latched `i_wdata` is written to `mem[idx]`. `o_mdr` and `o_ir` are unchanged.
- DONE lasts one cycle, then the block returns to IDLE unconditionally.
- The FSM must drop `i_memread`/`i_memwrite` by the cycle after `o_done`. A request still held in IDLE is treated as a new access.
- `o_ir` and `o_mdr` change only at read completion; they hold otherwise.

## Timing
- Reset values: state IDLE, counter 0, `o_ir`=0, `o_mdr`=0, `o_busy`=0, `o_done`=0, `o_err`=0. Memory contents are not cleared; they hold the `INIT_FILE` image or X.
- Request accepted at edge k:
  - `o_busy`=1 for cycles k+1 … k+LATENCY.
  - The data and write commit happen at edge k+LATENCY.
  - `o_done`=1 in the cycle after edge k+LATENCY.
  - The block is back in IDLE after edge k+LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- `o_busy` and `o_done` are never high together.
- `o_err` is high in the cycle after the rejecting edge, and never together with `o_busy`.
- Reset mid-access: the block returns to IDLE immediately and drops `o_busy`.
  - A pending write is not committed.
  - A pending read does not update `o_ir`/`o_mdr`; they are forced to 0.
- Reads and writes are not checked for same-address hazards. Accesses are serialized, so a read after a write always returns the new data.

## Test plan
- Fetch with LATENCY=2, `i_pc`=0x8, `mem[2]`=0x2008_0005, `i_memread`=1, `i_irwrite`=1, `i_iord`=0 → `o_busy` for 2 cycles, then `o_done`; `o_ir`=`o_mdr`=0x2008_0005.
- Store then load: `i_iord`=1, `i_aluout`=0x40, `i_wdata`=0xDEAD_BEEF, `i_memwrite` → `o_done`, `o_ir` unchanged. Then `i_memread`, `i_irwrite`=0 at 0x40 → `o_mdr`=0xDEAD_BEEF, `o_ir` unchanged.
- Rejected requests:
  - Misaligned `i_aluout`=0x42 with `i_memread` → `o_err` one cycle, no `o_busy`, `o_mdr` unchanged.
  - `i_memread` and `i_memwrite` together → `o_err`, memory unchanged.
- Wrap-around with DEPTH=256: write 0x1234 to 0x400, then read 0x000 → 0x1234.
- Reset mid-write: assert `i_rst_n`=0 one cycle after a write to 0x10 is accepted → all outputs 0 and IDLE; a later read of 0x10 returns the old value.
- LATENCY=1: back-to-back fetches at 0x0 and 0x4 → each completes in 3 cycles; `o_done` pulses exactly once per request.

Source files
------------

// File: rtl/multicycle_mem_port.sv
// Unified instruction/data memory port for the multi-cycle CPU: word accesses
// with a fixed wait-state latency, a busy/done handshake and IR/MDR capture.
module multicycle_mem_port #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 2,
   parameter string       INIT_FILE = ""
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_memread,
   input  logic        i_memwrite,
   input  logic        i_iord,
   input  logic        i_irwrite,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_aluout,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ir,
   output logic [31:0] o_mdr,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] addr_idx;
   logic [31:0]   wdata;
   logic          irwrite;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   req_addr;
   logic          req_bad;
   logic          mem_we;
   logic          unused_addr_bits;

   // Select the request address and classify the request as rejectable.
   always_comb begin
      req_addr = i_iord ? i_aluout : i_pc;
      req_bad  = (i_memread & i_memwrite) | (req_addr[1:0] != 2'b00);
   end

   // Upper address bits are ignored so accesses wrap modulo DEPTH words.
   assign unused_addr_bits = ^req_addr[31:AW+2];
   assign mem_we           = (state == WR_WAIT) && (cnt == '0);

   // Storage array; the write commits on the edge that leaves WR_WAIT.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem[addr_idx] <= wdata;
      end
   end

   // Access FSM with registered handshake outputs and IR/MDR capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_idx <= '0;
         wdata    <= 32'd0;
         irwrite  <= 1'b0;
         o_ir     <= 32'd0;
         o_mdr    <= 32'd0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (state)
            IDLE: begin
               addr_idx <= req_addr[AW+1:2];
               wdata    <= i_wdata;
               irwrite  <= i_irwrite;
               if (i_memread | i_memwrite) begin
                  if (req_bad) begin
                     o_err <= 1'b1;
                  end else begin
                     state  <= i_memread ? RD_WAIT : WR_WAIT;
                     cnt    <= CW'(LATENCY - 1);
                     o_busy <= 1'b1;
                  end
               end
            end
            RD_WAIT, WR_WAIT: begin
               if (cnt == '0) begin
                  if (state == RD_WAIT) begin
                     o_mdr <= mem[addr_idx];
                     if (irwrite) begin
                        o_ir <= mem[addr_idx];
                     end
                  end
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_mem_port.sv
// Directed bench for multicycle_mem_port: a LATENCY=2 instance for the main
// access/reject/wrap/reset sequences and a LATENCY=1 instance for back-to-back fetches.
module tb_multicycle_mem_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread, memwrite, memread1, memwrite1;
   logic        iord, irwrite;
   logic [31:0] pc, aluout, wdata;
   logic [31:0] ir, mdr, ir1, mdr1;
   logic        busy, done, err, busy1, done1, err1;
   int          checks = 0;
   int          errors = 0;
   int          done1_cnt = 0;

   always #5 clk = ~clk;

   multicycle_mem_port #(.DEPTH(256), .LATENCY(2), .INIT_FILE("")) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_memread(memread), .i_memwrite(memwrite),
      .i_iord(iord), .i_irwrite(irwrite), .i_pc(pc), .i_aluout(aluout),
      .i_wdata(wdata), .o_ir(ir), .o_mdr(mdr), .o_busy(busy), .o_done(done),
      .o_err(err)
   );

   multicycle_mem_port #(.DEPTH(256), .LATENCY(1), .INIT_FILE("")) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_memread(memread1), .i_memwrite(memwrite1),
      .i_iord(iord), .i_irwrite(irwrite), .i_pc(pc), .i_aluout(aluout),
      .i_wdata(wdata), .o_ir(ir1), .o_mdr(mdr1), .o_busy(busy1), .o_done(done1),
      .o_err(err1)
   );

   always @(posedge clk) begin
      if (done1) done1_cnt <= done1_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One LATENCY=2 access on dut with full busy/done timing checks.
   task automatic access(input string tag, input logic rd, input logic wr, input logic sel,
                         input logic irw, input logic [31:0] a, input logic [31:0] wd);
      memread = rd; memwrite = wr; iord = sel; irwrite = irw; wdata = wd;
      if (sel) aluout = a; else pc = a;
      step();
      memread = 1'b0; memwrite = 1'b0;
      chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_c1"}, {31'd0, done}, 32'd0);
      step();
      chk({tag, "_busy_c2"}, {31'd0, busy}, 32'd1);
      step();
      chk({tag, "_busy_c3"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_c3"}, {31'd0, done}, 32'd1);
      step();
      chk({tag, "_done_c4"}, {31'd0, done}, 32'd0);
   endtask

   // One LATENCY=1 access on dut1.
   task automatic access1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      memread1 = rd; memwrite1 = wr; iord = 1'b1; irwrite = 1'b0; aluout = a; wdata = wd;
      step();
      memread1 = 1'b0; memwrite1 = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; memread1 = 1'b0; memwrite1 = 1'b0;
      iord = 1'b0; irwrite = 1'b0; pc = 32'd0; aluout = 32'd0; wdata = 32'd0;
      #1;
      chk("rst_ir", ir, 32'd0);
      chk("rst_mdr", mdr, 32'd0);
      chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Preload the fetch word, then fetch it into IR and MDR.
      access("st_w2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h2008_0005);
      chk("st_w2_ir", ir, 32'd0);
      access("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'd0);
      chk("fetch_ir", ir, 32'h2008_0005);
      chk("fetch_mdr", mdr, 32'h2008_0005);

      access("st40", 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
      chk("st40_ir", ir, 32'h2008_0005);
      chk("st40_mdr", mdr, 32'h2008_0005);
      access("ld40", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
      chk("ld40_mdr", mdr, 32'hDEAD_BEEF);
      chk("ld40_ir", ir, 32'h2008_0005);

      // Misaligned read is rejected.
      memread = 1'b1; iord = 1'b1; aluout = 32'h42;
      step();
      memread = 1'b0;
      chk("mis_err", {31'd0, err}, 32'd1);
      chk("mis_busy", {31'd0, busy}, 32'd0);
      step();
      chk("mis_err_off", {31'd0, err}, 32'd0);
      chk("mis_busy2", {31'd0, busy}, 32'd0);
      chk("mis_mdr", mdr, 32'hDEAD_BEEF);

      // Read and write together is rejected and leaves memory alone.
      memread = 1'b1; memwrite = 1'b1; aluout = 32'h40; wdata = 32'h1111_1111;
      step();
      memread = 1'b0; memwrite = 1'b0;
      chk("both_err", {31'd0, err}, 32'd1);
      chk("both_busy", {31'd0, busy}, 32'd0);
      step();
      chk("both_err_off", {31'd0, err}, 32'd0);
      access("both_rd", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
      chk("both_mem", mdr, 32'hDEAD_BEEF);

      // Address 0x400 wraps onto word 0.
      access("wrap_st", 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0000_1234);
      access("wrap_ld", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0);
      chk("wrap_mdr", mdr, 32'h0000_1234);

      // LATENCY=1 back-to-back fetches at 0x0 and 0x4.
      access1(1'b0, 1'b1, 32'h0, 32'hAAAA_0000);
      access1(1'b0, 1'b1, 32'h4, 32'hBBBB_0004);
      memread1 = 1'b1; iord = 1'b0; irwrite = 1'b1; pc = 32'h0;
      step();
      chk("l1_busy_a", {31'd0, busy1}, 32'd1);
      chk("l1_done_a0", {31'd0, done1}, 32'd0);
      step();
      chk("l1_done_a", {30'd0, busy1, done1}, 32'd1);
      chk("l1_ir_a", ir1, 32'hAAAA_0000);
      pc = 32'h4;
      step();
      chk("l1_idle", {30'd0, busy1, done1}, 32'd0);
      step();
      memread1 = 1'b0;
      chk("l1_busy_b", {30'd0, busy1, done1}, 32'd2);
      step();
      chk("l1_done_b", {30'd0, busy1, done1}, 32'd1);
      chk("l1_ir_b", ir1, 32'hBBBB_0004);
      chk("l1_mdr_b", mdr1, 32'hBBBB_0004);
      step();
      step();
      chk("l1_quiet", {30'd0, busy1, done1}, 32'd0);
      chk("l1_done_count", done1_cnt, 32'd4);

      // Reset during a pending write discards it.
      access("old10", 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE_0010);
      memwrite = 1'b1; iord = 1'b1; aluout = 32'h10; wdata = 32'hBAD0_BAD0;
      step();
      memwrite = 1'b0;
      step();
      chk("rmw_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmw_flags", {29'd0, busy, done, err}, 32'd0);
      chk("rmw_ir", ir, 32'd0);
      chk("rmw_mdr", mdr, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("rmw_no_done", {29'd0, busy, done, err}, 32'd0);
      access("rmw_rd", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
      chk("rmw_old", mdr, 32'hCAFE_0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
